id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Pipeline register and operand-select stage between instruction decode and the ALU. Captures decoded operands and control, inserts bubbles on load-use hazards and flushes, and resolves RAW hazards by forwarding from EX/MEM and MEM/WB. It drives the ALU's `data1_i`, `data2_i` and `ALUCtrl_i` directly, plus the control and store data needed by the EX/MEM register. It also keeps a bubble counter for performance monitoring.

## Interface
- DATA_W, 32, datapath width
- RA_W, 5, register address width
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- id_valid_i  in  1  decode holds a real instruction
- id_rs1_addr_i / id_rs2_addr_i / id_rd_addr_i  in  RA_W  source and destination registers
- id_rs1_data_i / id_rs2_data_i  in  DATA_W  register-file read data
- id_imm_i  in  DATA_W  sign-extended immediate
- id_alu_ctrl_i  in  4  ALU op: AND 0000, XOR 0001, SLL 0010, ADD 0011, SUB 0100, MUL 0101, ADDI 0110, SRAI 0111, LW 1000, SW 1001
- id_alusrc_i, id_regwrite_i, id_memread_i, id_memwrite_i, id_memtoreg_i  in  1  decoded control
- flush_i  in  1  kill the instruction in ID (taken branch)
- exmem_regwrite_i  in  1; exmem_rd_i  in  RA_W; exmem_result_i  in  DATA_W  EX/MEM producer
- memwb_regwrite_i  in  1; memwb_rd_i  in  RA_W; memwb_data_i  in  DATA_W  MEM/WB producer
- id_stall_o  out  1  hold PC and IF/ID this cycle
- ex_valid_o  out  1  EX holds a real instruction
- ex_data1_o / ex_data2_o  out  DATA_W  ALU operands
- ex_alu_ctrl_o  out  4  ALU op
- ex_store_data_o  out  DATA_W  forwarded rs2 for SW
- ex_rd_o  out  RA_W; ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o  out  1
- bubble_cnt_o  out  16  bubbles inserted since reset, saturating

## Operation
- The EX register holds valid, rs1/rs2 addresses, rs1/rs2 data, imm, alu_ctrl, alusrc, rd and the four control bits.
- Each clock edge, in priority order:
  - rst_i: load a bubble and clear bubble_cnt_o.
  - flush_i: load a bubble.
  - hazard: load a bubble and increment the counter.
  - otherwise: capture the ID inputs, with valid = id_valid_i.
- Bubble contents: valid=0, all control bits 0, rd=0, alu_ctrl=0011 (ADD), data and imm 0.
- A source "uses rs2" when id_alusrc_i=0 or id_memwrite_i=1. rs1 is always used.
- Load-use hazard: ex_valid & ex_memread & ex_rd≠0 & ID source == ex_rd.
- id_stall_o = hazard & ~flush_i. Flush wins and the killed instruction is not stalled.
- Forwarding applies per source (rs1, rs2); first match wins:
  - EX/MEM, when exmem_regwrite_i=1, exmem_rd_i≠0 and exmem_rd_i == src: use exmem_result_i.
  - MEM/WB, when memwb_regwrite_i=1, memwb_rd_i≠0 and memwb_rd_i == src: use memwb_data_i.
  - Otherwise: use the captured register data.
  - x0 is never forwarded.
- Operand outputs:
  - ex_data1_o = forwarded rs1.
  - ex_data2_o = ex_alusrc ? imm : forwarded rs2.
  - ex_store_data_o = forwarded rs2.
- bubble_cnt_o counts hazard bubbles only (not flushes) and saturates at 0xFFFF.

## Timing
- All ex_* control outputs are registered: latency 1 cycle from ID inputs.
- ex_data1_o, ex_data2_o and ex_store_data_o are combinational from the EX register and the forwarding inputs, in the same cycle.
- id_stall_o is combinational from the ID inputs and the EX register; it must settle before the edge.
- Reset values: ex_valid_o=0, all control 0, ex_rd_o=0, ex_alu_ctrl_o=0011, ex_data1_o=0, ex_data2_o=0, ex_store_data_o=0, id_stall_o=0, bubble_cnt_o=0.
- Reset asserted mid-stall: the bubble is loaded and the counter is cleared, not incremented.
- Load-use hazard: exactly one bubble. The next cycle the load is in MEM/WB and forwarding supplies the value.

## Configuration
- FORWARD_EN defined: forwarding as above. Only load-use hazards stall.
- FORWARD_EN undefined:
  - No forwarding. ex_data1_o and ex_data2_o use the captured data only.
  - Hazard = a used ID source matches a nonzero rd of any in-flight writer: (ex_valid & ex_regwrite), exmem_regwrite_i, or memwb_regwrite_i.
  - A dependent instruction stalls up to 3 cycles. ID re-reads the register file each stalled cycle.

## Test plan
- Reset: hold rst_i 2 cycles -> all outputs at their reset values, ex_alu_ctrl_o=0011, bubble_cnt_o=0.
- Plain capture: ADD (x1=5, x2=7) with no hazards -> next cycle ex_data1_o=5, ex_data2_o=7, ex_alu_ctrl_o=0011, ex_valid_o=1.
- EX/MEM over MEM/WB priority (FORWARD_EN): EX holds SUB with rs1=x3, exmem_rd_i=x3 with result 0x10, memwb_rd_i=x3 with data 0x20 -> ex_data1_o=0x10. Repeat with rd=x0 on both -> captured data is used.
- Load-use: LW x4 in EX, ID is ADD x5,x4,x6 -> id_stall_o=1 for one cycle, one bubble loaded (ex_valid_o=0), bubble_cnt_o increments to 1, then ADD enters EX with x4 forwarded from MEM/WB.
- Flush during hazard: same as the load-use case with flush_i=1 -> id_stall_o=0, bubble loaded, bubble_cnt_o unchanged.
- Without FORWARD_EN: ADDI x1 followed by a dependent XOR -> id_stall_o high for 3 cycles, bubble_cnt_o=3, and XOR enters EX with the register-file value.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register and ALU operand select.
//
// Captures the decoded instruction into the EX register, inserts bubbles on
// flushes and hazards, and resolves RAW dependencies for the ALU operands.
//
// Ports
//   clk_i, rst_i                     clock, synchronous active-high reset
//   id_*                             decoded instruction from ID
//   flush_i                          kill the instruction in ID
//   exmem_*, memwb_*                 downstream producers (forwarding/hazards)
//   id_stall_o                       hold PC and IF/ID this cycle
//   ex_valid_o, ex_rd_o, ex_*_o      registered control for EX/MEM
//   ex_data1_o, ex_data2_o           ALU operands (combinational)
//   ex_alu_ctrl_o                    ALU op
//   ex_store_data_o                  rs2 value for stores
//   bubble_cnt_o                     saturating count of hazard bubbles
//
// Build option
//   FORWARD_EN  defined: forward from EX/MEM and MEM/WB, stall on load-use only.
//               undefined: no forwarding, stall until every in-flight writer
//               of a used source has retired.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [RA_W-1:0]   id_rs1_addr_i,
    input  logic [RA_W-1:0]   id_rs2_addr_i,
    input  logic [RA_W-1:0]   id_rd_addr_i,
    input  logic [DATA_W-1:0] id_rs1_data_i,
    input  logic [DATA_W-1:0] id_rs2_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [3:0]        id_alu_ctrl_i,
    input  logic              id_alusrc_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              id_memwrite_i,
    input  logic              id_memtoreg_i,
    input  logic              flush_i,
    input  logic              exmem_regwrite_i,
    input  logic [RA_W-1:0]   exmem_rd_i,
    input  logic [DATA_W-1:0] exmem_result_i,
    input  logic              memwb_regwrite_i,
    input  logic [RA_W-1:0]   memwb_rd_i,
    input  logic [DATA_W-1:0] memwb_data_i,
    output logic              id_stall_o,
    output logic              ex_valid_o,
    output logic [DATA_W-1:0] ex_data1_o,
    output logic [DATA_W-1:0] ex_data2_o,
    output logic [3:0]        ex_alu_ctrl_o,
    output logic [DATA_W-1:0] ex_store_data_o,
    output logic [RA_W-1:0]   ex_rd_o,
    output logic              ex_regwrite_o,
    output logic              ex_memread_o,
    output logic              ex_memwrite_o,
    output logic              ex_memtoreg_o,
    output logic [15:0]       bubble_cnt_o
);

    localparam logic [3:0] ALU_ADD = 4'b0011;

    logic                     vld_p0;
    logic [RA_W-1:0]          rs1_p0;
    logic [RA_W-1:0]          rs2_p0;
    logic [RA_W-1:0]          rd_p0;
    logic signed [DATA_W-1:0] rs1_data_p0;
    logic signed [DATA_W-1:0] rs2_data_p0;
    logic signed [DATA_W-1:0] imm_p0;
    logic [3:0]               alu_ctrl_p0;
    logic                     alusrc_p0;
    logic                     regwrite_p0;
    logic                     memread_p0;
    logic                     memwrite_p0;
    logic                     memtoreg_p0;
    logic [15:0]              bubble_cnt_p0;

    logic                     use_rs2;
    logic                     hazard;
    logic signed [DATA_W-1:0] op1;
    logic signed [DATA_W-1:0] op2;

    function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    // True when an enabled writer targets a nonzero register read by ID.
    function automatic logic src_match(input logic            wr_en,
                                       input logic [RA_W-1:0] wr_rd,
                                       input logic [RA_W-1:0] rs1,
                                       input logic [RA_W-1:0] rs2,
                                       input logic            rs2_used);
        return wr_en && (wr_rd != '0) &&
               ((wr_rd == rs1) || (rs2_used && (wr_rd == rs2)));
    endfunction

`ifdef FORWARD_EN
    // EX/MEM is younger than MEM/WB, so it is checked first; x0 never forwards.
    function automatic logic signed [DATA_W-1:0] fwd_sel(
        input logic [RA_W-1:0]          src,
        input logic signed [DATA_W-1:0] captured,
        input logic                     xw,
        input logic [RA_W-1:0]          xrd,
        input logic [DATA_W-1:0]        xres,
        input logic                     ww,
        input logic [RA_W-1:0]          wrd,
        input logic [DATA_W-1:0]        wdat);
        if ((src != '0) && xw && (xrd == src))
            return xres;
        if ((src != '0) && ww && (wrd == src))
            return wdat;
        return captured;
    endfunction
`endif

    assign use_rs2 = ~id_alusrc_i | id_memwrite_i;

`ifdef FORWARD_EN
    // Only a load in EX cannot be covered by forwarding next cycle.
    assign hazard = src_match(vld_p0 & memread_p0, rd_p0,
                              id_rs1_addr_i, id_rs2_addr_i, use_rs2);

    assign op1 = fwd_sel(rs1_p0, rs1_data_p0, exmem_regwrite_i, exmem_rd_i,
                         exmem_result_i, memwb_regwrite_i, memwb_rd_i, memwb_data_i);
    assign op2 = fwd_sel(rs2_p0, rs2_data_p0, exmem_regwrite_i, exmem_rd_i,
                         exmem_result_i, memwb_regwrite_i, memwb_rd_i, memwb_data_i);
`else
    // Without forwarding ID must wait until the writer has left MEM/WB.
    assign hazard = src_match(vld_p0 & regwrite_p0, rd_p0,
                              id_rs1_addr_i, id_rs2_addr_i, use_rs2)
                  | src_match(exmem_regwrite_i, exmem_rd_i,
                              id_rs1_addr_i, id_rs2_addr_i, use_rs2)
                  | src_match(memwb_regwrite_i, memwb_rd_i,
                              id_rs1_addr_i, id_rs2_addr_i, use_rs2);

    assign op1 = rs1_data_p0;
    assign op2 = rs2_data_p0;

    logic unused_fwd;
    assign unused_fwd = ^{exmem_result_i, memwb_data_i, rs1_p0, rs2_p0};
`endif

    // A flushed instruction is discarded, so it must not hold the front end.
    assign id_stall_o = hazard & ~flush_i;

    // ---- ID -> EX register boundary ----
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i || hazard) begin
            vld_p0      <= 1'b0;
            rs1_p0      <= '0;
            rs2_p0      <= '0;
            rd_p0       <= '0;
            rs1_data_p0 <= '0;
            rs2_data_p0 <= '0;
            imm_p0      <= '0;
            alu_ctrl_p0 <= ALU_ADD;
            alusrc_p0   <= 1'b0;
            regwrite_p0 <= 1'b0;
            memread_p0  <= 1'b0;
            memwrite_p0 <= 1'b0;
            memtoreg_p0 <= 1'b0;
        end else begin
            vld_p0      <= id_valid_i;
            rs1_p0      <= id_rs1_addr_i;
            rs2_p0      <= id_rs2_addr_i;
            rd_p0       <= id_rd_addr_i;
            rs1_data_p0 <= id_rs1_data_i;
            rs2_data_p0 <= id_rs2_data_i;
            imm_p0      <= id_imm_i;
            alu_ctrl_p0 <= id_alu_ctrl_i;
            alusrc_p0   <= id_alusrc_i;
            regwrite_p0 <= id_regwrite_i;
            memread_p0  <= id_memread_i;
            memwrite_p0 <= id_memwrite_i;
            memtoreg_p0 <= id_memtoreg_i;
        end
    end

    // Flush bubbles are not counted; reset overrides a pending stall.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            bubble_cnt_p0 <= '0;
        else if (hazard && !flush_i)
            bubble_cnt_p0 <= sat_inc(bubble_cnt_p0);
    end

    // ---- EX operand select ----
    assign ex_data1_o      = op1;
    assign ex_data2_o      = alusrc_p0 ? imm_p0 : op2;
    assign ex_store_data_o = op2;
    assign ex_valid_o      = vld_p0;
    assign ex_alu_ctrl_o   = alu_ctrl_p0;
    assign ex_rd_o         = rd_p0;
    assign ex_regwrite_o   = regwrite_p0;
    assign ex_memread_o    = memread_p0;
    assign ex_memwrite_o   = memwrite_p0;
    assign ex_memtoreg_o   = memtoreg_p0;
    assign bubble_cnt_o    = bubble_cnt_p0;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table-driven directed vectors plus randomized stimulus
// checked against a behavioural model of the ID/EX stage.
module tb_id_ex_stage;

    typedef struct packed {
        logic        rst, flush, valid;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic [3:0]  ctrl;
        logic        alusrc, rw, mr, mw, m2r;
        logic        xw;
        logic [4:0]  xrd;
        logic [31:0] xres;
        logic        ww;
        logic [4:0]  wrd;
        logic [31:0] wdat;
    } stim_t;

    typedef struct packed {
        logic        stall, valid;
        logic [31:0] d1, d2, sd;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        rw, mr, mw, m2r;
        logic [15:0] cnt;
    } out_t;

    typedef struct packed {
        stim_t s;
        out_t  e;
    } vec_t;

    logic        clk;
    logic        rst, id_valid, flush;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_d1, id_d2, id_imm;
    logic [3:0]  id_ctrl;
    logic        id_alusrc, id_rw, id_mr, id_mw, id_m2r;
    logic        xm_rw, wb_rw;
    logic [4:0]  xm_rd, wb_rd;
    logic [31:0] xm_res, wb_dat;
    logic        stall, ex_valid, ex_rw, ex_mr, ex_mw, ex_m2r;
    logic [31:0] ex_d1, ex_d2, ex_sd;
    logic [3:0]  ex_ctrl;
    logic [4:0]  ex_rd;
    logic [15:0] bcnt;

    int    vectors = 0;
    int    miscompares = 0;
    stim_t ex_m;
    int    cnt_m;
    vec_t  tbl[$];

    id_ex_stage dut (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid),
        .id_rs1_addr_i(id_rs1), .id_rs2_addr_i(id_rs2), .id_rd_addr_i(id_rd),
        .id_rs1_data_i(id_d1), .id_rs2_data_i(id_d2), .id_imm_i(id_imm),
        .id_alu_ctrl_i(id_ctrl), .id_alusrc_i(id_alusrc), .id_regwrite_i(id_rw),
        .id_memread_i(id_mr), .id_memwrite_i(id_mw), .id_memtoreg_i(id_m2r),
        .flush_i(flush),
        .exmem_regwrite_i(xm_rw), .exmem_rd_i(xm_rd), .exmem_result_i(xm_res),
        .memwb_regwrite_i(wb_rw), .memwb_rd_i(wb_rd), .memwb_data_i(wb_dat),
        .id_stall_o(stall), .ex_valid_o(ex_valid),
        .ex_data1_o(ex_d1), .ex_data2_o(ex_d2), .ex_alu_ctrl_o(ex_ctrl),
        .ex_store_data_o(ex_sd), .ex_rd_o(ex_rd),
        .ex_regwrite_o(ex_rw), .ex_memread_o(ex_mr), .ex_memwrite_o(ex_mw),
        .ex_memtoreg_o(ex_m2r), .bubble_cnt_o(bcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mk_id(logic v, logic [4:0] r1, logic [4:0] r2, logic [4:0] rd,
                                    logic [31:0] d1, logic [31:0] d2, logic [31:0] imm,
                                    logic [3:0] ctrl, logic asrc, logic rw, logic mr,
                                    logic mw, logic m2r);
        stim_t s;
        s = '0;
        s.valid = v; s.rs1 = r1; s.rs2 = r2; s.rd = rd;
        s.d1 = d1; s.d2 = d2; s.imm = imm; s.ctrl = ctrl;
        s.alusrc = asrc; s.rw = rw; s.mr = mr; s.mw = mw; s.m2r = m2r;
        return s;
    endfunction

    function automatic out_t mk_out(logic st, logic v, logic [31:0] d1, logic [31:0] d2,
                                    logic [31:0] sd, logic [3:0] ctrl, logic [4:0] rd,
                                    logic rw, logic mr, logic mw, logic m2r, logic [15:0] cnt);
        out_t o;
        o.stall = st; o.valid = v; o.d1 = d1; o.d2 = d2; o.sd = sd;
        o.ctrl = ctrl; o.rd = rd; o.rw = rw; o.mr = mr; o.mw = mw; o.m2r = m2r;
        o.cnt = cnt;
        return o;
    endfunction

    function automatic out_t bub(logic st, logic [15:0] cnt);
        return mk_out(st, 1'b0, 0, 0, 0, 4'h3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, cnt);
    endfunction

    function automatic stim_t with_x(stim_t s, logic [4:0] rd, logic [31:0] v);
        s.xw = 1'b1; s.xrd = rd; s.xres = v;
        return s;
    endfunction

    function automatic stim_t with_w(stim_t s, logic [4:0] rd, logic [31:0] v);
        s.ww = 1'b1; s.wrd = rd; s.wdat = v;
        return s;
    endfunction

    function automatic string fmt(out_t o);
        return $sformatf("stall=%0b vld=%0b d1=%h d2=%h sd=%h alu=%h rd=%0d rw=%0b mr=%0b mw=%0b m2r=%0b cnt=%0d",
                         o.stall, o.valid, o.d1, o.d2, o.sd, o.ctrl, o.rd,
                         o.rw, o.mr, o.mw, o.m2r, o.cnt);
    endfunction

    // ---- reference model: EX holds the last accepted instruction record ----
    function automatic logic [31:0] resolve(logic [4:0] a, logic [31:0] cap, stim_t s);
`ifdef FORWARD_EN
        logic        en[2];
        logic [4:0]  rd[2];
        logic [31:0] v[2];
        en = '{s.xw, s.ww}; rd = '{s.xrd, s.wrd}; v = '{s.xres, s.wdat};
        for (int i = 0; i < 2; i++)
            if (a != 0 && en[i] && rd[i] == a) return v[i];
`endif
        return cap;
    endfunction

    function automatic logic model_hazard(stim_t s);
        logic [4:0] w[$];
        logic       uses2;
        uses2 = !s.alusrc || s.mw;
`ifdef FORWARD_EN
        if (ex_m.valid && ex_m.mr) w.push_back(ex_m.rd);
`else
        if (ex_m.valid && ex_m.rw) w.push_back(ex_m.rd);
        if (s.xw) w.push_back(s.xrd);
        if (s.ww) w.push_back(s.wrd);
`endif
        foreach (w[i])
            if (w[i] != 0 && (w[i] == s.rs1 || (uses2 && w[i] == s.rs2))) return 1'b1;
        return 1'b0;
    endfunction

    function automatic out_t model_out(stim_t s);
        out_t        o;
        logic [31:0] r2;
        r2 = resolve(ex_m.rs2, ex_m.d2, s);
        o.stall = model_hazard(s) && !s.flush;
        o.valid = ex_m.valid;
        o.d1    = resolve(ex_m.rs1, ex_m.d1, s);
        o.d2    = ex_m.alusrc ? ex_m.imm : r2;
        o.sd    = r2;
        o.ctrl  = ex_m.ctrl; o.rd = ex_m.rd;
        o.rw = ex_m.rw; o.mr = ex_m.mr; o.mw = ex_m.mw; o.m2r = ex_m.m2r;
        o.cnt   = cnt_m[15:0];
        return o;
    endfunction

    task automatic model_step(stim_t s);
        stim_t bubble;
        logic  hz;
        bubble = mk_id(0, 0, 0, 0, 0, 0, 0, 4'h3, 0, 0, 0, 0, 0);
        hz = model_hazard(s);
        if (s.rst) begin
            ex_m = bubble; cnt_m = 0;
        end else if (s.flush) begin
            ex_m = bubble;
        end else if (hz) begin
            ex_m = bubble;
            if (cnt_m < 65535) cnt_m++;
        end else begin
            ex_m = s;
        end
    endtask

    task automatic drive(stim_t s);
        rst = s.rst; flush = s.flush; id_valid = s.valid;
        id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd;
        id_d1 = s.d1; id_d2 = s.d2; id_imm = s.imm; id_ctrl = s.ctrl;
        id_alusrc = s.alusrc; id_rw = s.rw; id_mr = s.mr; id_mw = s.mw; id_m2r = s.m2r;
        xm_rw = s.xw; xm_rd = s.xrd; xm_res = s.xres;
        wb_rw = s.ww; wb_rd = s.wrd; wb_dat = s.wdat;
    endtask

    // Drive, check at the falling edge, then advance the model with the edge.
    task automatic apply(stim_t s, out_t e, string name);
        out_t got;
        drive(s);
        @(negedge clk);
        got = mk_out(stall, ex_valid, ex_d1, ex_d2, ex_sd, ex_ctrl, ex_rd,
                     ex_rw, ex_mr, ex_mw, ex_m2r, bcnt);
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL %s: got {%s} expected {%s}", name, fmt(got), fmt(e));
        end
        @(posedge clk);
        model_step(s);
        #1;
    endtask

    task automatic add(stim_t s, out_t e);
        vec_t v;
        v.s = s; v.e = e;
        tbl.push_back(v);
    endtask

    initial begin
        stim_t idle, s, addv, sub, lw, dep, itype, sw, addi, xorv;

        idle = mk_id(0, 0, 0, 0, 0, 0, 0, 4'h3, 0, 0, 0, 0, 0);
        addv = mk_id(1, 1, 2, 3, 5, 7, 0, 4'h3, 0, 1, 0, 0, 0);
        sub  = mk_id(1, 3, 4, 5, 32'h111, 32'h222, 0, 4'h4, 0, 1, 0, 0, 0);

        // reset, plain capture, forwarding priority and x0
        s = idle; s.rst = 1'b1;
        add(s, bub(0, 0));
        add(addv, bub(0, 0));
        add(idle, mk_out(0, 1, 5, 7, 7, 4'h3, 3, 1, 0, 0, 0, 0));
        add(sub, bub(0, 0));
`ifdef FORWARD_EN
        add(with_w(with_x(idle, 3, 32'h10), 3, 32'h20),
            mk_out(0, 1, 32'h10, 32'h222, 32'h222, 4'h4, 5, 1, 0, 0, 0, 0));
`else
        add(with_w(with_x(idle, 3, 32'h10), 3, 32'h20),
            mk_out(0, 1, 32'h111, 32'h222, 32'h222, 4'h4, 5, 1, 0, 0, 0, 0));
`endif
        add(sub, bub(0, 0));
        add(with_w(with_x(idle, 0, 32'h10), 0, 32'h20),
            mk_out(0, 1, 32'h111, 32'h222, 32'h222, 4'h4, 5, 1, 0, 0, 0, 0));
        add(sub, bub(0, 0));
`ifdef FORWARD_EN
        add(with_x(with_w(idle, 4, 32'h44), 9, 32'h99),
            mk_out(0, 1, 32'h111, 32'h44, 32'h44, 4'h4, 5, 1, 0, 0, 0, 0));

        // load-use: one bubble, then MEM/WB supplies the loaded value
        lw    = mk_id(1, 1, 0, 4, 32'h100, 0, 8, 4'h8, 1, 1, 1, 0, 1);
        dep   = mk_id(1, 4, 6, 5, 32'hdead, 6, 0, 4'h3, 0, 1, 0, 0, 0);
        itype = mk_id(1, 2, 4, 6, 1, 2, 3, 4'h6, 1, 1, 0, 0, 0);
        sw    = mk_id(1, 2, 4, 0, 1, 2, 3, 4'h9, 1, 0, 0, 1, 0);
        add(lw, bub(0, 0));
        add(dep, mk_out(1, 1, 32'h100, 8, 0, 4'h8, 4, 1, 1, 0, 1, 0));
        add(with_x(dep, 4, 32'h108), bub(0, 1));
        add(with_w(idle, 4, 32'h77), mk_out(0, 1, 32'h77, 6, 6, 4'h3, 5, 1, 0, 0, 0, 1));
        // flush wins over the hazard
        add(lw, bub(0, 1));
        s = dep; s.flush = 1'b1;
        add(s, mk_out(0, 1, 32'h100, 8, 0, 4'h8, 4, 1, 1, 0, 1, 1));
        add(idle, bub(0, 1));
        // reset during a stall clears the counter
        add(lw, bub(0, 1));
        s = dep; s.rst = 1'b1;
        add(s, mk_out(1, 1, 32'h100, 8, 0, 4'h8, 4, 1, 1, 0, 1, 1));
        add(idle, bub(0, 0));
        // rs2 ignored for immediate ops, used for stores
        add(lw, bub(0, 0));
        add(itype, mk_out(0, 1, 32'h100, 8, 0, 4'h8, 4, 1, 1, 0, 1, 0));
        add(idle, mk_out(0, 1, 1, 3, 2, 4'h6, 6, 1, 0, 0, 0, 0));
        add(lw, bub(0, 0));
        add(sw, mk_out(1, 1, 32'h100, 8, 0, 4'h8, 4, 1, 1, 0, 1, 0));
        add(idle, bub(0, 1));
`else
        add(with_x(with_w(idle, 4, 32'h44), 9, 32'h99),
            mk_out(0, 1, 32'h111, 32'h222, 32'h222, 4'h4, 5, 1, 0, 0, 0, 0));

        // dependent op waits for the writer to pass EX, MEM and WB
        addi  = mk_id(1, 2, 0, 1, 32'h10, 0, 5, 4'h6, 1, 1, 0, 0, 0);
        xorv  = mk_id(1, 1, 3, 7, 32'hbad, 32'h33, 0, 4'h1, 0, 1, 0, 0, 0);
        itype = mk_id(1, 2, 1, 6, 1, 2, 3, 4'h6, 1, 1, 0, 0, 0);
        add(addi, bub(0, 0));
        add(xorv, mk_out(1, 1, 32'h10, 5, 0, 4'h6, 1, 1, 0, 0, 0, 0));
        add(with_x(xorv, 1, 32'h15), bub(1, 1));
        add(with_w(xorv, 1, 32'h15), bub(1, 2));
        s = xorv; s.d1 = 32'h15;
        add(s, bub(0, 3));
        add(idle, mk_out(0, 1, 32'h15, 32'h33, 32'h33, 4'h1, 7, 1, 0, 0, 0, 3));
        // flush wins over the hazard
        add(addi, bub(0, 3));
        s = xorv; s.flush = 1'b1;
        add(s, mk_out(0, 1, 32'h10, 5, 0, 4'h6, 1, 1, 0, 0, 0, 3));
        add(idle, bub(0, 3));
        // reset during a stall clears the counter
        add(addi, bub(0, 3));
        s = xorv; s.rst = 1'b1;
        add(s, mk_out(1, 1, 32'h10, 5, 0, 4'h6, 1, 1, 0, 0, 0, 3));
        add(idle, bub(0, 0));
        // rs2 ignored for immediate ops
        add(addi, bub(0, 0));
        add(itype, mk_out(0, 1, 32'h10, 5, 0, 4'h6, 1, 1, 0, 0, 0, 0));
        add(idle, mk_out(0, 1, 1, 3, 2, 4'h6, 6, 1, 0, 0, 0, 0));
`endif

        // untracked power-on reset
        ex_m = idle; cnt_m = 0;
        s = idle; s.rst = 1'b1;
        drive(s);
        repeat (2) @(posedge clk);
        model_step(s);
        #1;

        foreach (tbl[i])
            apply(tbl[i].s, tbl[i].e, $sformatf("vec[%0d]", i));

`ifndef FORWARD_EN
        // counter saturation under a held hazard
        s = idle; s.rst = 1'b1;
        apply(s, model_out(s), "sat_reset");
        s = with_w(idle, 1, 32'h5); s.rs1 = 5'd1;
        for (int i = 0; i < 66000; i++) begin
            if (cnt_m == 65535) break;
            drive(s);
            @(posedge clk);
            model_step(s);
            #1;
        end
        apply(s, model_out(s), "sat_hold0");
        apply(s, model_out(s), "sat_hold1");
        vectors++;
        if (bcnt !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL sat_value: got %h expected ffff", bcnt);
        end
`endif

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            s = '0;
            s.rst    = ($urandom_range(0, 63) == 0);
            s.flush  = ($urandom_range(0, 7) == 0);
            s.valid  = 1'($urandom);
            s.rs1    = 5'($urandom_range(0, 7));
            s.rs2    = 5'($urandom_range(0, 7));
            s.rd     = 5'($urandom_range(0, 7));
            s.d1     = $urandom; s.d2 = $urandom; s.imm = $urandom;
            s.ctrl   = 4'($urandom);
            s.alusrc = 1'($urandom); s.rw = 1'($urandom);
            s.mr     = ($urandom_range(0, 2) == 0);
            s.mw     = 1'($urandom); s.m2r = 1'($urandom);
            s.xw     = 1'($urandom); s.xrd = 5'($urandom_range(0, 7)); s.xres = $urandom;
            s.ww     = 1'($urandom); s.wrd = 5'($urandom_range(0, 7)); s.wdat = $urandom;
            apply(s, model_out(s), $sformatf("rand[%0d]", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
